nes_bus_arbiter: RTL



---
 rtl/nes_bus_pkg.sv | 29 ++
 rtl/nes_bus_mux.sv | 29 ++
 rtl/nes_bus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-domain bus definitions: widths, owner codes, arbiter states.
// Used by the bus arbiter and by the sprite-DMA and APU masters.
// Pure declarations; no logic.
package nes_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int OWN_W  = 2;

    localparam logic [OWN_W-1:0] OWN_CPU = 2'd0;
    localparam logic [OWN_W-1:0] OWN_SPR = 2'd1;
    localparam logic [OWN_W-1:0] OWN_DMC = 2'd2;

    typedef enum logic [2:0] {
        S_CPU  = 3'd0,
        S_HALT = 3'd1,
        S_SPR  = 3'd2,
        S_DMC  = 3'd3,
        S_REL  = 3'd4
    } state_e;

    // Address / write-not / write-data bundle a master puts on the shared bus.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wn;
        logic [DATA_W-1:0] wdata;
    } bus_t;

endpackage

// File: rtl/nes_bus_mux.sv
// 3:1 mux of the address/wn/wdata bundle, selected by the owner code.
// Latency: combinational, zero cycles.
// Backpressure: none; the owner code alone decides who drives.
module nes_bus_mux
    import nes_bus_pkg::*;
#(
    parameter logic [1:0] OWN_CPU = nes_bus_pkg::OWN_CPU,
    parameter logic [1:0] OWN_SPR = nes_bus_pkg::OWN_SPR,
    parameter logic [1:0] OWN_DMC = nes_bus_pkg::OWN_DMC
) (
    input  logic [1:0] owner_i,
    input  bus_t       cpu_i,
    input  bus_t       spr_i,
    input  bus_t       dmc_i,
    output bus_t       bus_o
);

    // Select the owning master's bundle; unknown codes fall back to the CPU.
    always_comb begin
        bus_o = cpu_i;
        case (owner_i)
            OWN_CPU: bus_o = cpu_i;
            OWN_SPR: bus_o = spr_i;
            OWN_DMC: bus_o = dmc_i;
            default: bus_o = cpu_i;
        endcase
    end

endmodule

// File: rtl/nes_bus_arbiter.sv
// System-bus owner: halts the 6502 via RDY and grants sprite DMA / DMC fetches.
// Latency: request -> RDY low 1 edge, grant 2 edges; release -> RDY high 2 edges.
// Backpressure: CPU write cycles defer the halt; requests wait, never dropped.
module nes_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter logic [1:0] OWN_CPU = nes_bus_pkg::OWN_CPU,
    parameter logic [1:0] OWN_SPR = nes_bus_pkg::OWN_SPR,
    parameter logic [1:0] OWN_DMC = nes_bus_pkg::OWN_DMC
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_rdy,
    input  logic        i_spr_req,
    output logic        o_spr_gnt,
    input  logic [15:0] i_spr_addr,
    input  logic        i_spr_wn,
    input  logic [7:0]  i_spr_wdata,
    input  logic        i_dmc_req,
    output logic        o_dmc_gnt,
    input  logic [15:0] i_dmc_addr,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    output logic [1:0]  o_bus_owner
);

    state_e state_q;
    state_e state_d;
    bus_t   cpu_bus;
    bus_t   spr_bus;
    bus_t   dmc_bus;
    bus_t   bus_sel;

    // State register; reset drops any in-flight grant straight back to the CPU.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DMC has priority over sprite DMA at every decision point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                // The 6502 ignores RDY on writes, so only halt on a read cycle.
                if ((i_spr_req || i_dmc_req) && i_cpu_wn) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (i_dmc_req) begin
                    state_d = S_DMC;
                end else if (i_spr_req) begin
                    state_d = S_SPR;
                end else begin
                    state_d = S_REL;
                end
            end
            S_SPR: begin
                if (i_dmc_req) begin
                    state_d = S_DMC;
                end else if (!i_spr_req) begin
                    state_d = S_REL;
                end
            end
            S_DMC: begin
                state_d = i_spr_req ? S_SPR : S_REL;
            end
            S_REL: begin
                state_d = S_CPU;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // Handshake outputs and owner code decode from the registered state only.
    always_comb begin
        o_cpu_rdy   = (state_q == S_CPU);
        o_spr_gnt   = (state_q == S_SPR);
        o_dmc_gnt   = (state_q == S_DMC);
        o_bus_owner = OWN_CPU;
        if (state_q == S_SPR) begin
            o_bus_owner = OWN_SPR;
        end else if (state_q == S_DMC) begin
            o_bus_owner = OWN_DMC;
        end
    end

    // Per-master bundles; a DMC fetch is always a read with idle write data.
    always_comb begin
        cpu_bus       = '{addr: i_cpu_addr, wn: i_cpu_wn, wdata: i_cpu_wdata};
        spr_bus       = '{addr: i_spr_addr, wn: i_spr_wn, wdata: i_spr_wdata};
        dmc_bus       = '{addr: i_dmc_addr, wn: 1'b1, wdata: 8'h00};
    end

    nes_bus_mux #(
        .OWN_CPU (OWN_CPU),
        .OWN_SPR (OWN_SPR),
        .OWN_DMC (OWN_DMC)
    ) u_mux (
        .owner_i (o_bus_owner),
        .cpu_i   (cpu_bus),
        .spr_i   (spr_bus),
        .dmc_i   (dmc_bus),
        .bus_o   (bus_sel)
    );

    // Unpack the selected bundle onto the shared bus ports.
    always_comb begin
        o_bus_addr  = bus_sel.addr;
        o_bus_wn    = bus_sel.wn;
        o_bus_wdata = bus_sel.wdata;
    end

endmodule
